// File: rtl/wave_freq_meter.sv
// Gated frequency / period / peak meter for a 10-bit sampled waveform.
// Rising crossings come from a Schmitt detector centred on the previous gate's midpoint.
module wave_freq_meter #(
    parameter int GATE_CYCLES = 12_000_000,
    parameter int HYST        = 32
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [9:0]  sample,
    output logic [26:0] freq_hz,
    output logic [23:0] period_cyc,
    output logic [9:0]  vmax,
    output logic [9:0]  vmin,
    output logic        meas_valid,
    output logic        sig_lost
);

    localparam logic [26:0] GATE_LAST = 27'(GATE_CYCLES - 1);
    localparam logic [10:0] HYST_W    = 11'(HYST);
    localparam logic [11:0] HYST2     = 12'(2 * HYST);

    typedef enum logic {
        GATE_S  = 1'b0,
        LATCH_S = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [26:0] gate_cnt_q, gate_cnt_d;
    logic        schmitt_q, schmitt_d;
    logic [9:0]  mid_q, mid_d;
    logic [26:0] edge_cnt_q, edge_cnt_d;
    logic [23:0] per_cnt_q, per_cnt_d;
    logic [23:0] period_q, period_d;
    logic        seen_edge_q, seen_edge_d;
    logic [9:0]  vmax_acc_q, vmax_acc_d;
    logic [9:0]  vmin_acc_q, vmin_acc_d;
    logic        any_valid_q, any_valid_d;
    logic [26:0] freq_q, freq_d;
    logic [23:0] period_out_q, period_out_d;
    logic [9:0]  vmax_q, vmax_d;
    logic [9:0]  vmin_q, vmin_d;
    logic        lost_q, lost_d;

    logic [10:0] hi_sum;
    logic [10:0] lo_diff;
    logic [9:0]  hi_thr;
    logic [9:0]  lo_thr;
    logic        rise;
    logic        fall;
    logic        gate_end;
    logic [26:0] edge_inc;
    logic [23:0] per_inc;
    logic [9:0]  vmax_upd;
    logic [9:0]  vmin_upd;
    logic        any_upd;
    logic [11:0] span;
    logic [10:0] mid_sum;
    logic        lost_now;

    // Saturating thresholds: the window is clipped to the 0..1023 code range.
    assign hi_sum  = {1'b0, mid_q} + HYST_W;
    assign lo_diff = {1'b0, mid_q} - HYST_W;
    assign hi_thr  = (hi_sum > 11'd1023) ? 10'd1023 : hi_sum[9:0];
    assign lo_thr  = lo_diff[10] ? 10'd0 : lo_diff[9:0];

    assign rise = sample_valid && !schmitt_q && (sample >= hi_thr);
    assign fall = sample_valid &&  schmitt_q && (sample <= lo_thr);

    assign gate_end = (state_q == GATE_S) && (gate_cnt_q == GATE_LAST);

    assign edge_inc = (rise && (edge_cnt_q != '1)) ? edge_cnt_q + 27'd1 : edge_cnt_q;
    assign per_inc  = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 24'd1;

    assign vmax_upd = (sample_valid && (sample > vmax_acc_q)) ? sample : vmax_acc_q;
    assign vmin_upd = (sample_valid && (sample < vmin_acc_q)) ? sample : vmin_acc_q;
    assign any_upd  = any_valid_q || sample_valid;

    // Final-cycle sample is folded in so the closing gate sees it.
    assign span     = {2'b00, vmax_upd} - {2'b00, vmin_upd};
    assign mid_sum  = {1'b0, vmax_upd} + {1'b0, vmin_upd};
    assign lost_now = (edge_inc == 27'd0) || !any_upd || (span < HYST2);

    assign meas_valid = (state_q == LATCH_S);
    assign freq_hz    = freq_q;
    assign period_cyc = period_out_q;
    assign vmax       = vmax_q;
    assign vmin       = vmin_q;
    assign sig_lost   = lost_q;

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        schmitt_d    = schmitt_q;
        mid_d        = mid_q;
        edge_cnt_d   = edge_inc;
        per_cnt_d    = per_inc;
        period_d     = period_q;
        seen_edge_d  = seen_edge_q;
        vmax_acc_d   = vmax_upd;
        vmin_acc_d   = vmin_upd;
        any_valid_d  = any_upd;
        freq_d       = freq_q;
        period_out_d = period_out_q;
        vmax_d       = vmax_q;
        vmin_d       = vmin_q;
        lost_d       = lost_q;

        case (state_q)
            GATE_S: begin
                if (gate_cnt_q == GATE_LAST) begin
                    state_d    = LATCH_S;
                    gate_cnt_d = '0;
                end else begin
                    gate_cnt_d = gate_cnt_q + 27'd1;
                end
            end
            LATCH_S: begin
                state_d    = GATE_S;
                gate_cnt_d = '0;
            end
            default: begin
                state_d    = GATE_S;
                gate_cnt_d = '0;
            end
        endcase

        if (rise) begin
            schmitt_d = 1'b1;
        end else if (fall) begin
            schmitt_d = 1'b0;
        end

        // The first crossing after reset only starts the period timer.
        if (rise) begin
            per_cnt_d   = '0;
            seen_edge_d = 1'b1;
            if (seen_edge_q) begin
                period_d = per_inc;
            end
        end

        // Results are published on entry to LATCH so they coincide with meas_valid.
        if (gate_end) begin
            lost_d       = lost_now;
            freq_d       = lost_now ? 27'd0 : edge_inc;
            period_out_d = lost_now ? 24'd0 : period_d;
            vmax_d       = any_upd ? vmax_upd : 10'd0;
            vmin_d       = any_upd ? vmin_upd : 10'd0;
            edge_cnt_d   = '0;
            vmax_acc_d   = 10'd0;
            vmin_acc_d   = 10'd1023;
            any_valid_d  = 1'b0;
            if (any_upd) begin
                mid_d = mid_sum[10:1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= GATE_S;
            gate_cnt_q   <= '0;
            schmitt_q    <= 1'b0;
            mid_q        <= 10'd512;
            edge_cnt_q   <= '0;
            per_cnt_q    <= '0;
            period_q     <= '0;
            seen_edge_q  <= 1'b0;
            vmax_acc_q   <= 10'd0;
            vmin_acc_q   <= 10'd1023;
            any_valid_q  <= 1'b0;
            freq_q       <= '0;
            period_out_q <= '0;
            vmax_q       <= '0;
            vmin_q       <= '0;
            lost_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            schmitt_q    <= schmitt_d;
            mid_q        <= mid_d;
            edge_cnt_q   <= edge_cnt_d;
            per_cnt_q    <= per_cnt_d;
            period_q     <= period_d;
            seen_edge_q  <= seen_edge_d;
            vmax_acc_q   <= vmax_acc_d;
            vmin_acc_q   <= vmin_acc_d;
            any_valid_q  <= any_valid_d;
            freq_q       <= freq_d;
            period_out_q <= period_out_d;
            vmax_q       <= vmax_d;
            vmin_q       <= vmin_d;
            lost_q       <= lost_d;
        end
    end

endmodule

// File: tb/tb_wave_freq_meter.sv
// Directed bench for wave_freq_meter with GATE_CYCLES=1000, HYST=32.
module tb_wave_freq_meter;

    localparam int GC = 1000;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [9:0]  sample = 10'd0;
    logic [26:0] freq_hz;
    logic [23:0] period_cyc;
    logic [9:0]  vmax;
    logic [9:0]  vmin;
    logic        meas_valid;
    logic        sig_lost;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    wave_freq_meter #(.GATE_CYCLES(GC), .HYST(32)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .sample_valid(sample_valid),
        .sample      (sample),
        .freq_hz     (freq_hz),
        .period_cyc  (period_cyc),
        .vmax        (vmax),
        .vmin        (vmin),
        .meas_valid  (meas_valid),
        .sig_lost    (sig_lost)
    );

    always #5 clk_in = ~clk_in;

    localparam int W_SQ = 0, W_C700 = 1, W_TRI = 2, W_NOISE = 3,
                   W_NOVALID = 4, W_LAST = 5, W_LATCH = 6;

    typedef struct {
        int kind;
        int gate;
        int freq;
        int per;
        int vmx;
        int vmn;
        int lost;
        int mid;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply(input int kind, input int t);
        int k;
        sample_valid = 1'b1;
        case (kind)
            W_SQ:      sample = ((t / 50) % 2 == 1) ? 10'd1023 : 10'd0;
            W_C700:    sample = 10'd700;
            W_TRI: begin
                k = t % 40;
                sample = (k < 20) ? 10'(400 + 10 * k) : 10'(600 - 10 * (k - 20));
            end
            W_NOISE:   sample = 10'(492 + (t * 13) % 41);
            W_NOVALID: begin
                sample_valid = 1'b0;
                sample = 10'd1023;
            end
            W_LAST:    sample = (t == 999) ? 10'd1023 : 10'd0;
            W_LATCH:   sample = (t == 1000) ? 10'd1023 : 10'd0;
            default:   sample = 10'd0;
        endcase
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_freq"}, int'(freq_hz), 0);
        chk({tag, "_period"}, int'(period_cyc), 0);
        chk({tag, "_vmax"}, int'(vmax), 0);
        chk({tag, "_vmin"}, int'(vmin), 0);
        chk({tag, "_mvalid"}, int'(meas_valid), 0);
        chk({tag, "_lost"}, int'(sig_lost), 1);
        chk({tag, "_mid"}, int'(dut.mid_q), 512);
    endtask

    task automatic do_reset(input int kind);
        rst_n = 1'b0;
        sample_valid = 1'b0;
        sample = 10'd0;
        repeat (3) @(posedge clk_in);
        #1;
        chk_reset_vals("reset");
        @(negedge clk_in);
        rst_n = 1'b1;
        cyc = 0;
        apply(kind, 0);
    endtask

    // Advance to cycle end_cyc, checking the meas_valid schedule every cycle.
    task automatic run_to(input int kind, input int end_cyc);
        logic exp_mv;
        while (cyc < end_cyc) begin
            @(posedge clk_in);
            #1;
            cyc++;
            exp_mv = (cyc == GC) || (cyc > GC && ((cyc - GC) % (GC + 1)) == 0);
            chk("meas_valid_sched", int'(meas_valid), int'(exp_mv));
            apply(kind, cyc);
        end
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{W_SQ,      1, 10, 100, 1023,   0, 0, 511};
        vecs[1] = '{W_C700,    1,  0,   0,  700, 700, 1, 700};
        vecs[2] = '{W_TRI,     1, 25,  40,  600, 400, 0, 500};
        vecs[3] = '{W_TRI,     2, 25,  40,  600, 400, 0, 500};
        vecs[4] = '{W_NOISE,   1,  0,   0,  532, 492, 1, 512};
        vecs[5] = '{W_NOVALID, 1,  0,   0,    0,   0, 1, 512};
        vecs[6] = '{W_LAST,    1,  1,   0, 1023,   0, 0, 511};
        vecs[7] = '{W_LATCH,   1,  0,   0,    0,   0, 1,   0};
        vecs[8] = '{W_LATCH,   2,  1,   0, 1023,   0, 0, 511};

        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            do_reset(vecs[i].kind);
            run_to(vecs[i].kind, GC + (vecs[i].gate - 1) * (GC + 1));
            chk({tag, "_mvalid"}, int'(meas_valid), 1);
            chk({tag, "_freq"}, int'(freq_hz), vecs[i].freq);
            chk({tag, "_period"}, int'(period_cyc), vecs[i].per);
            chk({tag, "_vmax"}, int'(vmax), vecs[i].vmx);
            chk({tag, "_vmin"}, int'(vmin), vecs[i].vmn);
            chk({tag, "_lost"}, int'(sig_lost), vecs[i].lost);
            @(posedge clk_in);
            #1;
            cyc++;
            chk({tag, "_mid"}, int'(dut.mid_q), vecs[i].mid);
            chk({tag, "_mvalid_drop"}, int'(meas_valid), 0);
            chk({tag, "_freq_hold"}, int'(freq_hz), vecs[i].freq);
        end

        // Reset 500 cycles into the second gate discards it and restarts the schedule.
        do_reset(W_SQ);
        run_to(W_SQ, GC + 1 + 500);
        chk("midrst_pre_freq", int'(freq_hz), 10);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("midrst");
        repeat (3) begin
            @(posedge clk_in);
            #1;
            chk("midrst_hold_mvalid", int'(meas_valid), 0);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        cyc = 0;
        apply(W_SQ, 0);
        run_to(W_SQ, GC);
        chk("midrst_mvalid", int'(meas_valid), 1);
        chk("midrst_freq", int'(freq_hz), 10);
        chk("midrst_period", int'(period_cyc), 100);
        chk("midrst_lost", int'(sig_lost), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_freq_meter.md
WAVE_FREQ_METER -- requirements
Module: wave_freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 12_000_000, which sets the gate length in clk_in cycles (1 s at 12 MHz); legal range 16..2^27-1.
REQ-002 SHALL have parameter HYST, default 32, which is the Schmitt half-window in sample codes.
REQ-003 SHALL have port clk_in, input, 1 bit: system clock, 12 MHz.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port sample_valid, input, 1 bit: qualifies sample.
REQ-006 SHALL have port sample, input, 10 bits: unsigned waveform code (0..1023), as produced by the team's DAC-path generator.
REQ-007 SHALL have port freq_hz, output, 27 bits: rising crossings counted in the last completed gate.
REQ-008 SHALL have port period_cyc, output, 24 bits: clk_in cycles between the last two rising crossings.
REQ-009 SHALL have port vmax and port vmin, outputs, 10 bits each: peak codes seen in the last gate.
REQ-010 SHALL have port meas_valid, output, 1 bit: one-cycle pulse when the outputs update.
REQ-011 SHALL have port sig_lost, output, 1 bit: no usable signal in the last gate.

Function
REQ-012 SHALL implement a 2-state FSM: GATE (counting), then LATCH (one cycle), then back to GATE; the state after reset is GATE with gate_cnt=0.
REQ-013 gate_cnt SHALL increment every clk_in cycle in GATE, independent of sample_valid; when gate_cnt==GATE_CYCLES-1 the next state SHALL be LATCH.
REQ-014 Crossing detector SHALL be a 1-bit Schmitt state (LO/HI) updated only on sample_valid cycles.
- LO->HI: sample >= mid+HYST, with the sum saturating at 1023.
- HI->LO: sample <= mid-HYST, with the difference saturating at 0.
- The state SHALL reset to LO.
REQ-015 mid SHALL be a 10-bit register, reset 512; at each LATCH, if at least one valid sample occurred, mid SHALL be set to (vmax_acc+vmin_acc)>>1 using an 11-bit sum, otherwise mid SHALL be unchanged.
REQ-016 Each LO->HI transition SHALL be a rising crossing and SHALL increment edge_cnt (27 bits), saturating at 2^27-1.
REQ-017 A crossing in the final GATE cycle SHALL count toward the closing gate; a crossing during LATCH SHALL count toward the new gate.
REQ-018 per_cnt (24 bits) SHALL increment every cycle and saturate at 24'hFFFFFF; on a rising crossing, period_cyc SHALL be set to per_cnt+1 (saturated) and per_cnt cleared, except that the first crossing after reset SHALL only clear per_cnt.
REQ-019 Each gate SHALL track vmax_acc (init 0) and vmin_acc (init 1023) from valid samples.
REQ-020 In LATCH the block SHALL do all of the following in one cycle:
- set freq_hz to edge_cnt;
- set vmax to vmax_acc and vmin to vmin_acc, or both to 0 if the gate had no valid sample;
- evaluate sig_lost;
- assert meas_valid;
- clear edge_cnt, reinitialise the accumulators, and clear gate_cnt.
REQ-021 sig_lost SHALL be 1 if edge_cnt==0, or if there was no valid sample, or if vmax_acc-vmin_acc < 2*HYST; otherwise sig_lost SHALL be 0.
REQ-022 When sig_lost is set, freq_hz SHALL be 0 and period_cyc SHALL be 0.
REQ-023 Outputs SHALL hold between LATCH cycles.
REQ-024 The measurement latency SHALL be meas_valid occurring exactly GATE_CYCLES+1 cycles after the previous meas_valid, or GATE_CYCLES cycles after reset release for the first one.

Reset
REQ-025 Under reset, all outputs SHALL be 0 except sig_lost, which SHALL be 1.
REQ-026 Under reset, mid SHALL be 512, accumulators SHALL be at their initial values, and the FSM SHALL be in GATE with gate_cnt=0.
REQ-027 Reset asserted mid-gate SHALL discard the partial gate, with no meas_valid pulse.

Verification (GATE_CYCLES=1000, HYST=32)
REQ-028 Square wave 0/1023 toggling every 50 cycles with sample_valid=1 SHALL give the following at the first meas_valid (cycle 1000): freq_hz=10, period_cyc=100, vmax=1023, vmin=0, sig_lost=0.
REQ-029 Constant sample=700 SHALL give freq_hz=0, period_cyc=0, sig_lost=1, vmax=vmin=700, and the next mid SHALL be 700.
REQ-030 Triangle 400..600 with a 40-cycle period SHALL give the following:
- gate 1, with mid=512: freq_hz=25 and sig_lost=0;
- gate 2: mid=500, and freq_hz=25 is held.
REQ-031 Noise of ±20 codes about 512, which is inside the hysteresis window, SHALL give freq_hz=0 and sig_lost=1.
REQ-032 sample_valid=0 for a whole gate SHALL give vmax=vmin=0, sig_lost=1, mid unchanged, and meas_valid still pulsing on schedule.
REQ-033 Reset pulsed at cycle 500 of a gate SHALL produce no meas_valid, outputs at reset values, and the next meas_valid 1000 cycles after release.
